onehot_rr_arbiter: RTL and testbench
====================================

Name: onehot_rr_arbiter

Overview:
- Upstream stage of the 8-to-3 one-hot encoder.
- Collects single-cycle request pulses from 8 sources into a pending register.
- Picks one pending source by round-robin and presents it as a registered one-hot grant word with a valid/ready handshake. The encoder consumes this word directly.
- Guarantees the downstream encoder only ever sees a legal one-hot value or all-zero, never a multi-hot one.

Parameters:
- N, 8, number of request sources and width of the one-hot grant (must be ≥2; the encoder pairing requires 8).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  request pulses, sampled every rising edge; bit i high = one event from source i.
- gnt_ready  input  1  consumer accepts the current grant this cycle.
- clr_ovr  input  1  synchronous clear of the ovr flag.
- gnt_onehot  output  N  registered one-hot grant; all-zero whenever gnt_valid=0.
- gnt_valid  output  1  gnt_onehot holds an offered grant.
- pend  output  N  current pending register (status).
- ovr  output  1  sticky flag: a request was lost because its source was already pending.

Behaviour:
- Reset (asynchronous, immediate, including mid-handshake):
  - pend=0, gnt_onehot=0, gnt_valid=0, ovr=0.
  - Round-robin pointer ptr=0; state=IDLE.
- Pending update at each edge:
  - pend_next = (pend & ~clr_mask) | req.
  - clr_mask is the granted bit when gnt_valid & gnt_ready, else 0.
  - A req on the bit being cleared in the same edge leaves that bit set (new event retained; no overrun).
- Round-robin selection:
  - Search starts at index ptr, ascending with wrap N-1→0.
  - The first set bit wins.
  - After a handshake on index i, ptr becomes (i+1) mod N.
  - ptr is unchanged when no handshake occurs.
- State IDLE (gnt_valid=0):
  - If pend≠0, load gnt_onehot with the selected bit, set gnt_valid, and go to OFFER at the next edge.
  - Requests arriving at the same edge are not considered until the following cycle.
  - Latency: a req pulse at edge E0 gives gnt_valid=1 after edge E1.
- State OFFER (gnt_valid=1):
  - gnt_onehot is held stable while gnt_ready=0, regardless of new requests. The grant is never withdrawn or changed except by reset.
  - On gnt_valid & gnt_ready at an edge:
    - If (pend & ~granted bit) ≠ 0, load the next grant in the same edge and stay in OFFER. This gives back-to-back grants with no bubble. The search uses the updated ptr and excludes same-edge req.
    - Otherwise clear gnt_onehot, drop gnt_valid, and return to IDLE.
- Overrun:
  - ovr sets at an edge where req[i]=1, pend[i]=1, and bit i is not being cleared at that edge.
  - ovr stays set until clr_ovr=1.
  - If a set condition and clr_ovr occur at the same edge, set wins.
  - The lost event is simply dropped; pend[i] stays 1.
- Width rule: gnt_onehot has at most one bit set at all times (it is checked as an invariant).
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset mid-offer: req=0x01, wait until gnt_valid=1, assert rst between edges → gnt_valid=0, gnt_onehot=0x00, pend=0x00 immediately, before the next edge.
- Single request: req=0x08 for one cycle, gnt_ready=1 → gnt_valid high exactly one edge later with gnt_onehot=0x08. After the handshake: gnt_valid=0, pend=0x00, ptr=4.
- Round-robin fairness: pulse req=0xFF once, gnt_ready held 1 → grants 0x01,0x02,…,0x80 on 8 consecutive cycles with no bubble, then gnt_valid=0.
- Pointer wrap: ptr=6 after a grant of bit 5, then pend=0x41 → first grant 0x40, then 0x01.
- Hold under backpressure: grant 0x04 offered, gnt_ready=0 for 5 cycles while req=0x02 pulses once → gnt_onehot stays 0x04. After ready, the next grant is 0x02.
- Overrun and same-edge retention:
  - req[3] pulsed twice while pend[3]=1 and not granted → ovr=1. A clr_ovr pulse → ovr=0.
  - req[3] pulsed on the edge its grant handshakes → pend[3] stays 1 and ovr stays 0.

Source files
------------

// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter that turns single-cycle request pulses into a registered
// one-hot grant word with a valid/ready handshake for the downstream encoder.
module onehot_rr_arbiter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         gnt_ready,
  input  logic         clr_ovr,
  output logic [N-1:0] gnt_onehot,
  output logic         gnt_valid,
  output logic [N-1:0] pend,
  output logic         ovr
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, OFFER} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] ptr, ptr_nxt, gnt_idx;
  logic [N-1:0]  gnt_nxt, clr_mask, pend_nxt, pend_rest;
  logic          handshake, ovr_set;

  // First set bit of vec, searching upward from start with wrap.
  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] vec,
                                           input logic [PW-1:0] start);
    logic [N-1:0]  res;
    logic          found;
    logic [PW-1:0] idx;
    res   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(start) + k) % N);
      if (!found && vec[idx]) begin
        res[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return res;
  endfunction

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_onehot[i]) gnt_idx = PW'(i);
    end
  end

  assign gnt_valid = (state == OFFER);
  assign handshake = gnt_valid & gnt_ready;
  assign clr_mask  = handshake ? gnt_onehot : '0;
  assign pend_nxt  = (pend & ~clr_mask) | req;
  assign pend_rest = pend & ~gnt_onehot;
  assign ovr_set   = |(req & pend & ~clr_mask);

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt_onehot;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (|pend) begin
          gnt_nxt   = rr_pick(pend, ptr);
          state_nxt = OFFER;
        end
      end
      OFFER: begin
        if (gnt_ready) begin
          ptr_nxt = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);
          // Back-to-back grant from what remains; same-edge requests wait.
          if (|pend_rest) begin
            gnt_nxt = rr_pick(pend_rest, ptr_nxt);
          end else begin
            gnt_nxt   = '0;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        gnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      gnt_onehot <= '0;
      pend       <= '0;
      ovr        <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      gnt_onehot <= gnt_nxt;
      pend       <= pend_nxt;
      if (ovr_set)      ovr <= 1'b1;
      else if (clr_ovr) ovr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Bench for onehot_rr_arbiter: directed scenarios followed by random traffic,
// all compared against an index-level behavioural model.
module tb_onehot_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       gnt_ready;
  logic       clr_ovr;
  logic [7:0] gnt_onehot;
  logic       gnt_valid;
  logic [7:0] pend;
  logic       ovr;

  int checks = 0;
  int errors = 0;

  // Model state: pending set, offered source index, pointer, overrun flag.
  logic [7:0] m_pend;
  logic       m_valid;
  int         m_gidx;
  int         m_ptr;
  logic       m_ovr;

  onehot_rr_arbiter #(.N(8)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt_ready(gnt_ready), .clr_ovr(clr_ovr),
    .gnt_onehot(gnt_onehot), .gnt_valid(gnt_valid), .pend(pend), .ovr(ovr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [7:0] v, input int start);
    for (int k = 0; k < 8; k++) begin
      if (v[(start + k) % 8]) return (start + k) % 8;
    end
    return -1;
  endfunction

  function automatic logic [7:0] m_gnt();
    logic [7:0] g;
    g = 8'h00;
    if (m_valid) g[m_gidx] = 1'b1;
    return g;
  endfunction

  task automatic model_reset();
    m_pend = 8'h00; m_valid = 1'b0; m_gidx = 0; m_ptr = 0; m_ovr = 1'b0;
  endtask

  task automatic model_edge(input logic [7:0] r, input logic rdy, input logic co);
    logic [7:0] clr, rest;
    logic       hs;
    int         p;
    hs  = m_valid && rdy;
    clr = hs ? m_gnt() : 8'h00;
    if ((r & m_pend & ~clr) != 8'h00) m_ovr = 1'b1;
    else if (co)                      m_ovr = 1'b0;
    if (!m_valid) begin
      p = pick(m_pend, m_ptr);
      if (p >= 0) begin m_valid = 1'b1; m_gidx = p; end
    end else if (hs) begin
      m_ptr = (m_gidx + 1) % 8;
      rest  = m_pend & ~clr;
      p     = pick(rest, m_ptr);
      if (p >= 0) m_gidx = p;
      else        m_valid = 1'b0;
    end
    m_pend = (m_pend & ~clr) | r;
  endtask

  task automatic chk_all();
    chk("gnt_valid",  gnt_valid,  m_valid);
    chk("gnt_onehot", gnt_onehot, m_gnt());
    chk("pend",       pend,       m_pend);
    chk("ovr",        ovr,        m_ovr);
    chk("onehot_inv", ($countones(gnt_onehot) <= 1), 1);
  endtask

  // Apply inputs, take one edge, advance the model, compare just after the edge.
  task automatic step(input logic [7:0] r, input logic rdy, input logic co = 1'b0);
    req = r; gnt_ready = rdy; clr_ovr = co;
    @(posedge clk);
    model_edge(r, rdy, co);
    #1;
    chk_all();
  endtask

  task automatic async_reset();
    #1 rst = 1'b1;
    #1;
    chk("rst_valid",  gnt_valid,  1'b0);
    chk("rst_onehot", gnt_onehot, 8'h00);
    chk("rst_pend",   pend,       8'h00);
    chk("rst_ovr",    ovr,        1'b0);
    model_reset();
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 8'h00; gnt_ready = 1'b0; clr_ovr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all();
    rst = 1'b0;

    // Reset in the middle of an offer.
    step(8'h01, 1'b0);
    step(8'h00, 1'b0);
    chk("offer_before_rst", gnt_valid, 1'b1);
    async_reset();

    // Single request, one-edge latency, pointer lands on 4.
    step(8'h08, 1'b1);
    chk("single_latency0", gnt_valid, 1'b0);
    step(8'h00, 1'b1);
    chk("single_gnt", gnt_onehot, 8'h08);
    step(8'h00, 1'b1);
    chk("single_done", {gnt_valid, pend}, 9'h000);
    step(8'h18, 1'b0);
    step(8'h00, 1'b0);
    chk("ptr4_first", gnt_onehot, 8'h10);
    step(8'h00, 1'b1);
    chk("ptr4_second", gnt_onehot, 8'h08);
    step(8'h00, 1'b1);

    // Bring pointer to 0, then all eight sources at once.
    step(8'h80, 1'b1);
    step(8'h00, 1'b1);
    step(8'h00, 1'b1);
    step(8'hFF, 1'b1);
    step(8'h00, 1'b1);
    chk("rr_0", gnt_onehot, 8'h01);
    for (int k = 1; k < 8; k++) begin
      step(8'h00, 1'b1);
      chk("rr_seq", gnt_onehot, 8'h01 << k);
    end
    step(8'h00, 1'b1);
    chk("rr_end", gnt_valid, 1'b0);

    // Pointer wrap after granting bit 5.
    step(8'h20, 1'b1);
    step(8'h00, 1'b1);
    step(8'h00, 1'b1);
    step(8'h41, 1'b1);
    step(8'h00, 1'b1);
    chk("wrap_first", gnt_onehot, 8'h40);
    step(8'h00, 1'b1);
    chk("wrap_second", gnt_onehot, 8'h01);
    step(8'h00, 1'b1);

    // Hold under backpressure.
    step(8'h04, 1'b0);
    step(8'h00, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step((k == 0) ? 8'h02 : 8'h00, 1'b0);
      chk("hold", gnt_onehot, 8'h04);
    end
    step(8'h00, 1'b1);
    chk("after_hold", gnt_onehot, 8'h02);
    step(8'h00, 1'b1);

    // Overrun on a pending, non-granted source, then clear.
    step(8'h0C, 1'b0);
    step(8'h00, 1'b0);
    chk("ovr_gnt", gnt_onehot, 8'h04);
    step(8'h08, 1'b0);
    step(8'h08, 1'b0);
    chk("ovr_set", ovr, 1'b1);
    step(8'h00, 1'b0, 1'b1);
    chk("ovr_clr", ovr, 1'b0);
    step(8'h00, 1'b1);
    chk("same_edge_gnt", gnt_onehot, 8'h08);
    step(8'h08, 1'b1);
    chk("same_edge_keep", {ovr, pend}, 9'h008);
    step(8'h00, 1'b1);
    chk("same_edge_regnt", gnt_onehot, 8'h08);
    step(8'h00, 1'b1);

    // Random traffic with occasional overrun clears and async resets.
    for (int n = 0; n < 3000; n++) begin
      step(8'($urandom & $urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 299) == 0) async_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
